// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow line-memory port between Icache and Dcache.
// One requester is granted at a time and the grant is held until mem_ready;
// every completion is followed by one IDLE cycle before re-arbitration.
// Build option ARB_RR_EN: replaces fixed Dcache priority and the starvation
// counter with round-robin between the two requesters.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | no grant, downstream outputs 0, arbitrate pending reqs
// GNT_I    | Icache owns the memory port until mem_ready
// GNT_D    | Dcache owns the memory port until mem_ready
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 28,
    parameter int LINE_W       = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [LINE_W-1:0] i_mem_wdata,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        arb_grant
);

    // State codes double as the arb_grant encoding.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GNT_I = 2'b01;
    localparam logic [1:0] ST_GNT_D = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
    logic              i_pend, d_pend;

`ifdef ARB_RR_EN
    // 1 = Dcache received the most recent grant, 0 = Icache.
    logic              last_d_q, last_d_d;
`else
    logic [3:0]        starve_q, starve_d;
`endif

    assign i_pend = i_mem_read | i_mem_write;
    assign d_pend = d_mem_read | d_mem_write;

    // Next-state arbitration and fairness bookkeeping.
    always_comb begin
        state_d = state_q;
`ifdef ARB_RR_EN
        last_d_d = last_d_q;
`else
        starve_d = starve_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_pend && d_pend) begin
`ifdef ARB_RR_EN
                    state_d = last_d_q ? ST_GNT_I : ST_GNT_D;
`else
                    state_d = (starve_q == 4'(STARVE_LIMIT)) ? ST_GNT_I : ST_GNT_D;
`endif
                end else if (d_pend) begin
                    state_d = ST_GNT_D;
                end else if (i_pend) begin
                    state_d = ST_GNT_I;
                end
`ifdef ARB_RR_EN
                if (state_d == ST_GNT_D) begin
                    last_d_d = 1'b1;
                end else if (state_d == ST_GNT_I) begin
                    last_d_d = 1'b0;
                end
`else
                // Only D grants that bypass a waiting Icache count toward starvation.
                if (state_d == ST_GNT_D) begin
                    if (!i_pend) begin
                        starve_d = 4'd0;
                    end else if (starve_q != 4'(STARVE_LIMIT)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (state_d == ST_GNT_I) begin
                    starve_d = 4'd0;
                end
`endif
            end
            ST_GNT_I, ST_GNT_D: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and fairness registers.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= ST_IDLE;
`ifdef ARB_RR_EN
            last_d_q <= 1'b0;
`else
            starve_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_RR_EN
            last_d_q <= last_d_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    // Each cache keeps the last line returned to it while the other one is served.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (state_q == ST_GNT_I && mem_ready) begin
                i_rdata_q <= mem_rdata;
            end
            if (state_q == ST_GNT_D && mem_ready) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    // Downstream request and upstream response routing for the current owner.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        i_mem_rdata = i_rdata_q;
        d_mem_rdata = d_rdata_q;
        case (state_q)
            ST_GNT_I: begin
                mem_read    = i_mem_read;
                mem_write   = i_mem_write;
                mem_addr    = i_mem_addr;
                mem_wdata   = i_mem_wdata;
                i_mem_ready = mem_ready;
                i_mem_rdata = mem_rdata;
            end
            ST_GNT_D: begin
                mem_read    = d_mem_read;
                mem_write   = d_mem_write;
                mem_addr    = d_mem_addr;
                mem_wdata   = d_mem_wdata;
                d_mem_ready = mem_ready;
                d_mem_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    assign arb_grant = state_q;

endmodule
